phase_timer: RTL and testbench
==============================

# phase_timer

Parametrised phase-duration timer for the traffic controller. It counts a programmable number of time slots, each `CLK_FREQ/TICK_HZ` clocks long, and reports elapsed and remaining slots. It emits a single-cycle `done` pulse at expiry and supports pause, abort, restart and auto-reload. The traffic FSM loads one phase length per light state and advances on `done`.

## Interface
- `CLK_FREQ`, default 125_000_000: input clock frequency in Hz.
- `TICK_HZ`, default 10: slot rate; the default gives 0.1 s slots.
- `SLOT_W`, default 7: width of the slot count.
- `CLK`  in  1: clock.
- `RST`  in  1: reset, synchronous, active-high.
- `time_slot`  in  SLOT_W: phase length in slots; sampled only on `start`.
- `start`  in  1: pulse; loads `time_slot` and (re)starts counting.
- `pause`  in  1: level; freezes counting while high.
- `abort`  in  1: pulse; stops the timer without signalling `done`.
- `auto_reload`  in  1: sampled on `start`; 1 restarts automatically at every expiry.
- `busy`  out  1: high when state is not IDLE.
- `done`  out  1: one-cycle expiry pulse.
- `tick`  out  1: one-cycle pulse at each slot boundary.
- `elapsed`  out  SLOT_W: completed slots.
- `remain`  out  SLOT_W: equals `target - elapsed`.

## Operation
- `DIV = CLK_FREQ/TICK_HZ` is computed at elaboration. Elaboration must fail unless `CLK_FREQ % TICK_HZ == 0` and `DIV >= 2`.
- Prescaler width is `$clog2(DIV)`. It counts 0..DIV-1 only in RUN.
- Registers:
  - `target` (SLOT_W) and `reload` are latched on `start`.
  - `elapsed` is an SLOT_W counter.
- States:
  - IDLE → RUN on `start` with `time_slot != 0`.
  - RUN → PAUSE while `pause` is high.
  - PAUSE → RUN when `pause` is low.
  - RUN → IDLE on the final tick when `reload == 0`.
  - RUN stays in RUN on the final tick when `reload == 1`.
  - RUN or PAUSE → IDLE on `abort`.
- `start` in any state reloads `target`/`reload`, clears the prescaler and `elapsed`, and enters RUN. A restart never produces `done`.
- `start` with `time_slot == 0`: state stays IDLE, `target = 0`, and `done` pulses the next cycle.
- `tick` is asserted in the cycle the prescaler equals DIV-1 in RUN. On that edge the prescaler wraps to 0 and `elapsed` increments.
- Final tick (`elapsed == target-1` at a tick edge):
  - `done` is registered high in the next cycle.
  - One-shot: `elapsed` becomes `target` and is held in IDLE, so `remain = 0`.
  - Reload: `elapsed` becomes 0 and counting continues with no dead cycle.
- PAUSE holds the prescaler and `elapsed`. `tick` stays low.
- `abort`: state IDLE, prescaler = 0, `elapsed` = 0, `target` = 0, no `done`.
- Input priority: RST > abort > start > pause.
- `time_slot` and `auto_reload` changes while not starting are ignored.

## Timing
- Reset values: state IDLE; `busy`, `done`, `tick`, `elapsed`, `remain`, `target`, `reload` and the prescaler are all 0.
- Latency: with `start` sampled at edge E0 and N = `time_slot`, `done` is high during the cycle after edge E0 + N·DIV. Each paused cycle adds one cycle.
- `busy` rises the cycle after `start` and falls in the same cycle `done` rises (one-shot).
- `done` is high for exactly 1 cycle. `tick` is high for exactly 1 cycle, N times per phase.
- `start` in the same cycle as the final tick: the restart wins and `done` is suppressed.
- `pause` in the same cycle as the final tick: PAUSE is not entered for that tick. The tick completes first.
- RST mid-operation returns all registers to their reset values on the next edge, with no `done`.

## Structure
- Shared package `traffic_pkg` holds:
  - the `phase_state_t` enum (IDLE, RUN, PAUSE);
  - a default `SLOT_W`;
  - the `DIV` helper function.
- Sub-module `tick_gen(DIV)`: prescaler with `en` and `clr` inputs and a `tick` output. It is reusable for display blinking.

## Test plan
Use `CLK_FREQ=100`, `TICK_HZ=10` (DIV=10), `SLOT_W=7`.
- `time_slot=5`, `start` at E0 → ticks at E0+10, 20, 30, 40, 50; `done` high for exactly the one cycle after E0+50; `elapsed` 0→5; `remain` 5→0; `busy` high for 50 cycles.
- `time_slot=0` `start` → `done` pulses the next cycle; `busy` is never high; `remain` = 0.
- `time_slot=4` with `pause` high for 7 cycles starting at E0+15 → `done` after E0+47; `elapsed` holds at 1 during the pause.
- `auto_reload=1`, `time_slot=3` → `done` after E0+30, 60 and 90; `busy` stays 1; `elapsed` wraps 2→0; `abort` at E0+95 → IDLE, `elapsed=0`, no further `done`.
- `start` and `abort` in the same cycle → IDLE, no `done`. `start` with `time_slot=2` at E0+25 during a 5-slot run → `done` only after E0+45.
- RST asserted at E0+33 during a run → all outputs 0 the next cycle; no `done` through E0+60.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types, defaults and divider helper for the traffic controller
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } phase_state_t;

    localparam int SLOT_W_DEF = 7;

    // Clocks per slot; the caller is expected to reject configurations that do not divide evenly.
    function automatic int phase_div(input int clk_freq, input int tick_hz);
        return clk_freq / tick_hz;
    endfunction

endpackage

// File: rtl/phase_timer_if.sv
// rtl/phase_timer_if.sv - control/status bundle between the traffic FSM and the phase timer
interface phase_timer_if #(
    parameter int SLOT_W = traffic_pkg::SLOT_W_DEF
);
    logic [SLOT_W-1:0] time_slot;
    logic              start;
    logic              pause;
    logic              abort;
    logic              auto_reload;
    logic              busy;
    logic              done;
    logic              tick;
    logic [SLOT_W-1:0] elapsed;
    logic [SLOT_W-1:0] remain;

    modport master (
        output time_slot, start, pause, abort, auto_reload,
        input  busy, done, tick, elapsed, remain
    );

    modport slave (
        input  time_slot, start, pause, abort, auto_reload,
        output busy, done, tick, elapsed, remain
    );
endinterface

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - enable/clear prescaler emitting one tick every DIV enabled clocks
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_top;

    assign at_top = (cnt_q == CNT_W'(DIV - 1));
    assign tick_o = en_i && at_top;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_top ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - programmable slot timer with pause, abort, restart and auto-reload
module phase_timer
    import traffic_pkg::*;
#(
    parameter int CLK_FREQ = 125_000_000,
    parameter int TICK_HZ  = 10,
    parameter int SLOT_W   = SLOT_W_DEF
) (
    input logic          CLK,
    input logic          RST,
    phase_timer_if.slave bus
);
    localparam int DIV = phase_div(CLK_FREQ, TICK_HZ);

    if (((CLK_FREQ % TICK_HZ) != 0) || (DIV < 2)) begin : g_bad_cfg
        $error("phase_timer: CLK_FREQ must be a multiple of TICK_HZ with DIV >= 2");
    end

    phase_state_t      state_q, state_d;
    logic [SLOT_W-1:0] elapsed_q, elapsed_d;
    logic [SLOT_W-1:0] target_q, target_d;
    logic              reload_q, reload_d;
    logic              done_q, done_d;
    logic              tick, final_tick, presc_en, presc_clr;

    // Any abort or start realigns the slot grid to the next clock.
    assign presc_en  = (state_q == RUN);
    assign presc_clr = bus.abort || bus.start;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk_i  (CLK),
        .rst_i  (RST),
        .en_i   (presc_en),
        .clr_i  (presc_clr),
        .tick_o (tick)
    );

    assign final_tick = tick && (elapsed_q == target_q - SLOT_W'(1));

    always_comb begin
        state_d   = state_q;
        elapsed_d = elapsed_q;
        target_d  = target_q;
        reload_d  = reload_q;
        done_d    = 1'b0;
        if (bus.abort) begin
            state_d   = IDLE;
            elapsed_d = '0;
            target_d  = '0;
            reload_d  = 1'b0;
        end else if (bus.start) begin
            target_d  = bus.time_slot;
            reload_d  = bus.auto_reload;
            elapsed_d = '0;
            // A zero-length phase completes immediately without ever becoming busy.
            state_d   = (bus.time_slot != '0) ? RUN : IDLE;
            done_d    = (bus.time_slot == '0);
        end else begin
            case (state_q)
                RUN: begin
                    if (final_tick) begin
                        done_d = 1'b1;
                        if (reload_q) begin
                            elapsed_d = '0;
                            state_d   = RUN;
                        end else begin
                            elapsed_d = target_q;
                            state_d   = IDLE;
                        end
                    end else begin
                        if (tick) begin
                            elapsed_d = elapsed_q + SLOT_W'(1);
                        end
                        state_d = bus.pause ? PAUSE : RUN;
                    end
                end
                PAUSE: begin
                    if (!bus.pause) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            elapsed_q <= '0;
            target_q  <= '0;
            reload_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            elapsed_q <= elapsed_d;
            target_q  <= target_d;
            reload_q  <= reload_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.tick    = tick;
    assign bus.elapsed = elapsed_q;
    assign bus.remain  = target_q - elapsed_q;
endmodule

// File: tb/tb_phase_timer.sv
// tb/tb_phase_timer.sv - directed bench for phase_timer with a clock-count reference model
module tb_phase_timer;
    localparam int DIV = 10;
    localparam int SW  = 7;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    phase_timer_if #(.SLOT_W(SW)) bus();

    phase_timer #(.CLK_FREQ(100), .TICK_HZ(10), .SLOT_W(SW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    int e0 = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int tick_cnt, done_cnt, busy_cnt, last_done_rel, first_tick_rel;

    always @(posedge CLK) cyc <= cyc + 1;

    // Reference: a phase is N*DIV counted clocks; paused clocks do not count.
    bit          m_active, m_paused, m_reload, m_done;
    logic [SW-1:0] m_target, m_hold;
    int          m_run;

    always @(posedge CLK) begin
        m_done <= 1'b0;
        if (RST) begin
            m_active <= 0; m_paused <= 0; m_reload <= 0;
            m_target <= '0; m_hold <= '0; m_run <= 0;
        end else if (bus.abort) begin
            m_active <= 0; m_paused <= 0;
            m_target <= '0; m_hold <= '0; m_run <= 0;
        end else if (bus.start) begin
            m_target <= bus.time_slot;
            m_reload <= bus.auto_reload;
            m_run    <= 0;
            m_paused <= 0;
            m_hold   <= '0;
            m_active <= (bus.time_slot != 0);
            m_done   <= (bus.time_slot == 0);
        end else if (m_active && !m_paused) begin
            if (m_run + 1 == int'(m_target) * DIV) begin
                m_done <= 1'b1;
                m_run  <= 0;
                if (!m_reload) begin
                    m_active <= 0;
                    m_hold   <= m_target;
                end
            end else begin
                m_run    <= m_run + 1;
                m_paused <= bus.pause;
            end
        end else if (m_active) begin
            m_paused <= bus.pause;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        logic [SW-1:0] exp_el;
        logic          exp_tick;
        if (cyc >= 1) begin
            exp_el   = m_active ? SW'(m_run / DIV) : m_hold;
            exp_tick = m_active && !m_paused && ((m_run % DIV) == DIV - 1);
            check("busy",    bus.busy,    m_active);
            check("done",    bus.done,    m_done);
            check("tick",    bus.tick,    exp_tick);
            check("elapsed", bus.elapsed, exp_el);
            check("remain",  bus.remain,  m_target - exp_el);
            if (bus.tick) begin
                tick_cnt++;
                if (first_tick_rel < 0) first_tick_rel = cyc - e0;
            end
            if (bus.done) begin
                done_cnt++;
                last_done_rel = cyc - e0;
            end
            if (bus.busy) busy_cnt++;
        end
    end

    task automatic next();
        @(posedge CLK);
        #2;
    endtask

    task automatic clear_stats();
        tick_cnt = 0; done_cnt = 0; busy_cnt = 0;
        last_done_rel = -1; first_tick_rel = -1;
    endtask

    task automatic do_start(input int ts, input bit ar);
        bus.time_slot   = SW'(ts);
        bus.auto_reload = ar;
        bus.start       = 1'b1;
        next();
        e0 = cyc;
        clear_stats();
        bus.start       = 1'b0;
        bus.time_slot   = 7'h55;
        bus.auto_reload = ~ar;
    endtask

    task automatic wait_rel(input int rel);
        while (cyc < e0 + rel) next();
    endtask

    initial begin
        bus.time_slot = '0; bus.start = 0; bus.pause = 0;
        bus.abort = 0; bus.auto_reload = 0;
        clear_stats();
        repeat (3) next();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_tick", bus.tick, 0);
        check("rst_elapsed", bus.elapsed, 0);
        check("rst_remain", bus.remain, 0);
        RST = 1'b0;
        repeat (2) next();

        do_start(5, 0);
        wait_rel(60);
        check("t1_ticks", tick_cnt, 5);
        check("t1_first_tick", first_tick_rel, 9);
        check("t1_dones", done_cnt, 1);
        check("t1_done_at", last_done_rel, 50);
        check("t1_busy_cycles", busy_cnt, 50);
        check("t1_elapsed", bus.elapsed, 5);
        check("t1_remain", bus.remain, 0);

        do_start(0, 0);
        wait_rel(5);
        check("t2_dones", done_cnt, 1);
        check("t2_done_at", last_done_rel, 0);
        check("t2_busy_cycles", busy_cnt, 0);
        check("t2_remain", bus.remain, 0);

        do_start(4, 0);
        wait_rel(14);
        bus.pause = 1'b1;
        wait_rel(18);
        check("t3_elapsed_paused", bus.elapsed, 1);
        wait_rel(21);
        bus.pause = 1'b0;
        wait_rel(60);
        check("t3_dones", done_cnt, 1);
        check("t3_done_at", last_done_rel, 47);
        check("t3_ticks", tick_cnt, 4);

        do_start(3, 1);
        wait_rel(94);
        bus.abort = 1'b1;
        next();
        bus.abort = 1'b0;
        wait_rel(130);
        check("t4_dones", done_cnt, 3);
        check("t4_last_done", last_done_rel, 90);
        check("t4_busy_cycles", busy_cnt, 95);
        check("t4_busy", bus.busy, 0);
        check("t4_elapsed", bus.elapsed, 0);

        do_start(5, 0);
        wait_rel(4);
        bus.time_slot = 3; bus.start = 1'b1; bus.abort = 1'b1;
        next();
        bus.start = 1'b0; bus.abort = 1'b0;
        wait_rel(70);
        check("t5a_dones", done_cnt, 0);
        check("t5a_busy_cycles", busy_cnt, 5);
        check("t5a_busy", bus.busy, 0);

        do_start(5, 0);
        wait_rel(24);
        bus.time_slot = 2; bus.start = 1'b1;
        next();
        bus.start = 1'b0;
        wait_rel(60);
        check("t5b_dones", done_cnt, 1);
        check("t5b_done_at", last_done_rel, 45);

        do_start(5, 0);
        wait_rel(32);
        RST = 1'b1;
        next();
        RST = 1'b0;
        check("t6_busy", bus.busy, 0);
        check("t6_elapsed", bus.elapsed, 0);
        check("t6_remain", bus.remain, 0);
        check("t6_tick", bus.tick, 0);
        wait_rel(60);
        check("t6_dones", done_cnt, 0);

        repeat (3) next();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
